// File: rtl/tt_sweep_ctrl_if.sv
// Row stream from the truth-table sweeper to its consumer.
// A row transfers on every rising edge where row_valid and row_ready are both 1;
// once raised, row_valid and row_data stay fixed until that transfer happens.
interface tt_sweep_ctrl_if;
    logic       row_valid;
    logic       row_ready;
    logic [4:0] row_data;

    modport master (output row_valid, output row_data, input row_ready);
    modport slave  (input row_valid, input row_data, output row_ready);
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input combination of one selected boolean function, samples its
// output after a settle delay, streams each row and builds the 16-bit truth table.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE      = 1,
    parameter logic [7:0]  NARROW_MASK = 8'b1010_0011
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            sel,
    input  logic [7:0]            y_i,
    tt_sweep_ctrl_if.master       rowIf,
    output logic                  a_o,
    output logic                  b_o,
    output logic                  c_o,
    output logic                  d_o,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           tt_word,
    output logic [1:0]            stateDbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     stateQ, stateNext;
    logic [2:0] selQ;
    logic [3:0] rowCnt;
    logic [3:0] settleCnt;
    logic [4:0] rowDataQ;
    logic       rowValid;
    logic       narrow;
    logic       isLast;
    logic       ySel;
    logic [3:0] rowNext;

    // 3-input functions only see A,B,C; D is parked at 0 for them.
    function automatic logic [3:0] inputsFor(input logic [3:0] row, input logic isNarrow);
        return isNarrow ? {row[2:0], 1'b0} : row;
    endfunction

    assign narrow  = NARROW_MASK[selQ];
    assign isLast  = narrow ? (rowCnt == 4'd7) : (rowCnt == 4'd15);
    assign ySel    = y_i[selQ];
    assign rowNext = rowCnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) stateQ <= IDLE;
        else       stateQ <= stateNext;
    end

    always_comb begin
        stateNext = stateQ;
        rowValid  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (stateQ)
            IDLE: begin
                if (start) stateNext = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (settleCnt == 4'd0) stateNext = EMIT;
            end
            EMIT: begin
                busy     = 1'b1;
                rowValid = 1'b1;
                if (rowIf.row_ready) stateNext = isLast ? DONE : WAIT;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            selQ                   <= 3'd0;
            rowCnt                 <= 4'd0;
            settleCnt              <= 4'd0;
            rowDataQ               <= 5'd0;
            tt_word                <= 16'd0;
            {a_o, b_o, c_o, d_o}   <= 4'd0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (start) begin
                        selQ                 <= sel;
                        rowCnt               <= 4'd0;
                        settleCnt            <= SETTLE_CNT;
                        tt_word              <= 16'd0;
                        {a_o, b_o, c_o, d_o} <= 4'd0;
                    end
                end
                WAIT: begin
                    if (settleCnt != 4'd0) begin
                        settleCnt <= settleCnt - 4'd1;
                    end else begin
                        tt_word[rowCnt] <= ySel;
                        rowDataQ        <= {ySel, rowCnt};
                    end
                end
                EMIT: begin
                    // New inputs launch on the handshake edge so settling starts immediately.
                    if (rowIf.row_ready && !isLast) begin
                        rowCnt               <= rowNext;
                        settleCnt            <= SETTLE_CNT;
                        {a_o, b_o, c_o, d_o} <= inputsFor(rowNext, narrow);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rowIf.row_valid = rowValid;
    assign rowIf.row_data  = rowDataQ;
    assign stateDbg        = stateQ;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: reference functions for the eight lab exercises,
// a SETTLE=1 unit with a one-cycle-late function model and a SETTLE=0 unit.
module tb_tt_sweep_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start, start0;
    logic [2:0]  sel, sel0;
    logic [7:0]  yReg, y0;
    logic        a_o, b_o, c_o, d_o, busy, done;
    logic        a0, b0, c0, d0, busy0, done0;
    logic [15:0] tt_word, tt0;
    logic [1:0]  stateDbg, stateDbg0;

    tt_sweep_ctrl_if rowBus();
    tt_sweep_ctrl_if rowBus0();

    tt_sweep_ctrl #(.SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .y_i(yReg), .rowIf(rowBus),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o), .busy(busy), .done(done),
        .tt_word(tt_word), .stateDbg(stateDbg)
    );

    tt_sweep_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .sel(sel0), .y_i(y0), .rowIf(rowBus0),
        .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0), .busy(busy0), .done(done0),
        .tt_word(tt0), .stateDbg(stateDbg0)
    );

    // ejer2 = ~B, ejer3 = even parity, ejer6 = ~B|C; the rest are arbitrary but distinct.
    function automatic logic [7:0] funcs(input logic a, input logic b, input logic c, input logic d);
        logic [7:0] y;
        y[0] = (a & b) | c;
        y[1] = ~b;
        y[2] = ~(a ^ b ^ c ^ d);
        y[3] = a | d;
        y[4] = a & ~d;
        y[5] = ~b | c;
        y[6] = b ^ d;
        y[7] = a & c;
        return y;
    endfunction

    // The slow unit's functions answer one cycle after their inputs move.
    always @(posedge clk) yReg <= funcs(a_o, b_o, c_o, d_o);
    assign y0 = funcs(a0, b0, c0, d0);
    assign rowBus0.row_ready = 1'b1;

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          doneAt;
    int          rowsSeen;
    logic [15:0] yOrder;
    bit          orderOk;
    bit          dHigh;

    function automatic bit isNarrow(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd1) || (s == 3'd5) || (s == 3'd7);
    endfunction

    // Runs one sweep on the SETTLE=1 unit; returns on the negedge where done is seen.
    task automatic runSweep(input logic [2:0] s, input int stallRow, input int stallCycles,
                            input logic [4:0] stallData, input logic [3:0] stallIn,
                            input bit injectStart);
        int cyc;
        int stallLeft;
        bit stallArmed;
        bit sawDone;
        rowsSeen = 0; yOrder = 16'd0; orderOk = 1'b1; dHigh = 1'b0; doneAt = -1;
        stallLeft = 0; stallArmed = (stallCycles > 0); sawDone = 1'b0;
        @(negedge clk);
        start = 1'b1; sel = s; rowBus.row_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (!sawDone && cyc <= 200) begin
            if (injectStart) begin
                if (cyc == 10) begin start = 1'b1; sel = 3'd0; end
                else if (cyc == 11) start = 1'b0;
            end
            if (isNarrow(s) && d_o) dHigh = 1'b1;
            if (stallLeft == 0 && stallArmed && rowBus.row_valid &&
                rowBus.row_data[3:0] == 4'(stallRow)) begin
                stallLeft  = stallCycles;
                stallArmed = 1'b0;
            end
            if (stallLeft > 0) begin
                checkEq("stall_valid", rowBus.row_valid, 1'b1);
                checkEq("stall_data", rowBus.row_data, stallData);
                checkEq("stall_inputs", {a_o, b_o, c_o, d_o}, stallIn);
                rowBus.row_ready = 1'b0;
                stallLeft--;
            end else begin
                rowBus.row_ready = 1'b1;
                if (rowBus.row_valid) begin
                    if (rowBus.row_data[3:0] != rowsSeen[3:0]) orderOk = 1'b0;
                    yOrder[rowsSeen[3:0]] = rowBus.row_data[4];
                    rowsSeen++;
                end
            end
            if (done) begin
                sawDone = 1'b1;
                doneAt  = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        checkEq("sweep_done_seen", sawDone, 1'b1);
    endtask

    task automatic waitDone(input int limit);
        int cyc;
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        checkEq("wait_done", done, 1'b1);
    endtask

    initial begin
        int cyc;
        int extraDone;
        start = 1'b0; sel = 3'd0; start0 = 1'b0; sel0 = 3'd0;
        rowBus.row_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkEq("reset_outputs", {a_o, b_o, c_o, d_o, rowBus.row_valid, rowBus.row_data,
                                  busy, done, tt_word}, 32'd0);
        checkEq("reset_state", stateDbg, 2'd0);
        checkEq("reset_outputs0", {a0, b0, c0, d0, rowBus0.row_valid, rowBus0.row_data,
                                   busy0, done0, tt0}, 32'd0);
        reset = 1'b0;

        // ejer2, 8 rows
        runSweep(3'd1, -1, 0, 5'd0, 4'd0, 1'b0);
        checkEq("e2_done_cycle", doneAt, 25);
        checkEq("e2_rows", rowsSeen, 8);
        checkEq("e2_order", orderOk, 1'b1);
        checkEq("e2_row_y", yOrder, 16'h0033);
        checkEq("e2_tt", tt_word, 16'h0033);
        checkEq("e2_d_low", dHigh, 1'b0);
        checkEq("e2_busy_in_done", busy, 1'b1);
        @(negedge clk);
        checkEq("e2_done_pulse", done, 1'b0);
        checkEq("e2_idle_busy", busy, 1'b0);
        checkEq("e2_idle_state", stateDbg, 2'd0);
        checkEq("e2_tt_hold", tt_word, 16'h0033);

        // ejer3, 16 rows, then back-to-back start held after DONE
        runSweep(3'd2, -1, 0, 5'd0, 4'd0, 1'b0);
        checkEq("e3_done_cycle", doneAt, 49);
        checkEq("e3_rows", rowsSeen, 16);
        checkEq("e3_order", orderOk, 1'b1);
        checkEq("e3_row_y", yOrder, 16'h9669);
        checkEq("e3_tt", tt_word, 16'h9669);
        start = 1'b1; sel = 3'd5;
        @(negedge clk);
        checkEq("b2b_idle_cycle", stateDbg, 2'd0);
        @(negedge clk);
        checkEq("b2b_accepted", stateDbg, 2'd1);
        checkEq("b2b_busy", busy, 1'b1);
        checkEq("b2b_tt_cleared", tt_word, 16'h0000);
        start = 1'b0;
        waitDone(200);
        checkEq("b2b_tt", tt_word, 16'h00BB);

        // ejer6 with consumer stalled 5 cycles on row 3
        runSweep(3'd5, 3, 5, 5'b1_0011, 4'b0110, 1'b0);
        checkEq("e6_done_cycle", doneAt, 30);
        checkEq("e6_rows", rowsSeen, 8);
        checkEq("e6_row_y", yOrder, 16'h00BB);
        checkEq("e6_tt", tt_word, 16'h00BB);
        checkEq("e6_d_low", dHigh, 1'b0);

        // start pulsed mid-sweep must be ignored
        runSweep(3'd2, -1, 0, 5'd0, 4'd0, 1'b1);
        checkEq("inj_done_cycle", doneAt, 49);
        checkEq("inj_tt", tt_word, 16'h9669);
        extraDone = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) extraDone++;
        end
        checkEq("inj_single_done", extraDone, 0);
        checkEq("inj_idle", stateDbg, 2'd0);

        // reset at row 6
        @(negedge clk);
        start = 1'b1; sel = 3'd2;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(rowBus.row_valid && rowBus.row_data[3:0] == 4'd6) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkEq("rst_reach_row6", rowBus.row_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkEq("rst_outputs", {a_o, b_o, c_o, d_o, rowBus.row_valid, rowBus.row_data,
                                busy, done, tt_word}, 32'd0);
        checkEq("rst_state", stateDbg, 2'd0);
        reset = 1'b0;
        @(negedge clk);
        checkEq("rst_no_done", done, 1'b0);
        checkEq("rst_stay_idle", stateDbg, 2'd0);
        runSweep(3'd2, -1, 0, 5'd0, 4'd0, 1'b0);
        checkEq("rst_resweep_cycle", doneAt, 49);
        checkEq("rst_resweep_tt", tt_word, 16'h9669);

        // SETTLE = 0 unit
        @(negedge clk);
        start0 = 1'b1; sel0 = 3'd2;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        while (!done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkEq("s0_done_seen", done0, 1'b1);
        checkEq("s0_done_cycle", cyc, 33);
        checkEq("s0_tt", tt0, 16'h9669);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that exhaustively exercises the lab's eight combinational boolean functions (ejer1..ejer8) one at a time. On a start request it drives every input combination of the selected function, waits a settle interval, samples that function's output, and streams each row out over a valid/ready handshake. It also assembles the complete truth table into a 16-bit word. It sits between the eight function instances (whose outputs arrive on `y_i`) and a display or check consumer.

## Interface
- `SETTLE`, default 1: extra wait cycles after the inputs change before `y_i` is sampled; legal range 0..15.
- `NARROW_MASK`, default 8'b1010_0011: bit k = 1 means function k is 3-input (ejer1, ejer2, ejer6, ejer8); otherwise it is 4-input.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `sel`  in  3  function index (0 = ejer1 .. 7 = ejer8); latched on an accepted start.
- `y_i`  in  8  outputs of the eight function instances; bit k = ejer(k+1).
- `row_ready`  in  1  consumer ready for the current row.
- `a_o`, `b_o`, `c_o`, `d_o`  out  1 each  registered function inputs A, B, C, D.
- `row_valid`  out  1  `row_data` is valid.
- `row_data`  out  5  {sampled y, row[3:0]}.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `tt_word`  out  16  truth table; bit r = output for row r; unused rows read 0.

## Operation
- States: IDLE, WAIT, EMIT, DONE.
- **IDLE**
  - `busy` = 0.
  - On `start` = 1: latch `sel_q` = `sel`, set row = 0, clear `tt_word`, load the settle counter with SETTLE, and go to WAIT.
- **WAIT**
  - `busy` = 1. The inputs are driven from the row count.
  - 4-input functions: {A,B,C,D} = row[3:0].
  - 3-input functions: {A,B,C} = row[2:0] and D = 0.
  - If the counter is nonzero, decrement it and stay in WAIT.
  - If the counter is 0:
    - capture `y_i[sel_q]` into `tt_word[row]` and into `row_data[4]`;
    - set `row_data[3:0]` = row;
    - go to EMIT.
- **EMIT**
  - `row_valid` = 1. `row_data` and `a_o`..`d_o` are held stable.
  - When `row_valid` and `row_ready` are both 1 at a rising edge:
    - if row = last (7 for narrow functions, 15 for 4-input), go to DONE;
    - otherwise increment row, drive the new inputs on that same edge, reload the counter with SETTLE, and go to WAIT.
- **DONE**
  - `done` = 1 for exactly one cycle; `busy` = 1 during that cycle.
  - Next state is IDLE.
- `tt_word` holds its value after DONE until the next accepted start clears it.
- `start` is ignored outside IDLE. `sel` is ignored except on the accepting edge.
- `row_valid` never deasserts without a completed handshake. `row_ready` has no effect outside EMIT.
- **Reset**, mid-sweep or otherwise: on the next edge the state is IDLE and every output is 0. The partial sweep is discarded and no `done` is produced.

## Timing
- Reset value of every output (`a_o`..`d_o`, `row_valid`, `row_data`, `busy`, `done`, `tt_word`) is 0.
- WAIT lasts SETTLE+1 cycles per row. EMIT lasts at least 1 cycle, plus any cycles with `row_ready` low.
- Inputs change on the edge that enters WAIT, so the function sees stable inputs for SETTLE+1 cycles before the sample edge.
- With `row_ready` held at 1, each row takes SETTLE+2 cycles.
  - `done` is high in cycle N·(SETTLE+2)+1 after the edge that accepts start, where N = 8 or 16.
  - SETTLE = 1, 16 rows: `done` is high in cycle 49.
- `busy` rises on the edge that accepts start and falls on the edge that leaves DONE.
- Back-to-back operation: a `start` held high in the cycle after DONE is accepted.

## Test plan
- Reset, then `start`, `sel` = 1 (ejer2, Y = ~B), `row_ready` = 1 -> 8 rows; `row_data[4]` sequence 1,1,0,0,1,1,0,0; `tt_word` = 0x0033; `d_o` = 0 throughout; `done` in cycle 25.
- `sel` = 2 (ejer3) -> 16 rows; `tt_word` = 0x9669 (even-parity rows 0,3,5,6,9,10,12,15); `done` in cycle 49.
- `sel` = 5 (ejer6, ~B|C), `row_ready` low for 5 cycles at row 3 -> `row_valid` is held and `row_data` = 5'b1_0011 stays stable; `a_o`..`d_o` do not change; final `tt_word` = 0x00BB.
- `start` pulsed with `sel` = 0 during a `sel` = 2 sweep -> ignored; the result is still 0x9669, with exactly one `done`.
- `reset` asserted at row 6 of a sweep -> next cycle all outputs are 0 and the state is IDLE; a fresh `sel` = 2 sweep then yields 0x9669.
- SETTLE = 0 build, `sel` = 2 -> 2 cycles per row; `done` in cycle 33; `tt_word` = 0x9669.
